// File: rtl/note_event_tracker.sv
// note_event_tracker
//   Turns the per-frame pitch stream into discrete note events. An onset is
//   confirmed after STABLE_FRAMES identical frames, a held note survives short
//   silent dropouts (fewer than RELEASE_FRAMES in a row), and its length is
//   measured in duration units of FRAMES_PER_UNIT frames, saturating at
//   MAX_UNITS. Each finished note is reported once as a registered
//   {note, duration} pair, qualified by a single-cycle note_dec strobe.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   frame_valid  one analysis frame is presented this cycle
//   frame_note   frame code: letter[7:4], octave[3:1], sharp[0]
//   flush        force-end the current note (end of song)
//   note         code of the last emitted note
//   duration     length of the last emitted note in units (1..MAX_UNITS)
//   note_dec     single-cycle strobe: note and duration were just updated
//   tracking     high while a note is being held
module note_event_tracker #(
  parameter int unsigned STABLE_FRAMES   = 3,
  parameter int unsigned RELEASE_FRAMES  = 2,
  parameter int unsigned FRAMES_PER_UNIT = 4,
  parameter int unsigned MAX_UNITS       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [7:0] frame_note,
  input  logic       flush,
  output logic [7:0] note,
  output logic [3:0] duration,
  output logic       note_dec,
  output logic       tracking
);

  // Length is kept as {units, sub}: units = ceil(frame_cnt / FRAMES_PER_UNIT),
  // sub = frames counted inside the current (partial) unit, 1..FRAMES_PER_UNIT.
  // On onset confirmation frame_cnt starts at STABLE_FRAMES, so the pair is
  // preloaded with the constants below.
  localparam int unsigned INIT_UNITS_I =
    (STABLE_FRAMES + FRAMES_PER_UNIT - 1) / FRAMES_PER_UNIT;
  localparam int unsigned INIT_SUB_I =
    STABLE_FRAMES - (INIT_UNITS_I - 1) * FRAMES_PER_UNIT;
  // Onset already at or past saturation: emit straight away and lock.
  localparam bit INIT_SAT = (STABLE_FRAMES >= MAX_UNITS * FRAMES_PER_UNIT);

  localparam logic [4:0] INIT_UNITS = 5'(INIT_UNITS_I);
  localparam logic [4:0] INIT_SUB   = 5'(INIT_SUB_I);
  localparam logic [4:0] FPU        = 5'(FRAMES_PER_UNIT);
  localparam logic [4:0] MAX_U5     = 5'(MAX_UNITS);
  localparam logic [3:0] MAX_U4     = 4'(MAX_UNITS);
  localparam logic [4:0] STABLE_N   = 5'(STABLE_FRAMES);
  localparam logic [4:0] RELEASE_N  = 5'(RELEASE_FRAMES);
  localparam logic [3:0] INIT_DUR   =
    (INIT_UNITS_I > MAX_UNITS) ? MAX_U4 : 4'(INIT_UNITS_I);

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HOLD,
    LOCK
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cand_q, cand_d;          // candidate, and held note in HOLD
  logic [3:0] cand_cnt_q, cand_cnt_d;
  logic [3:0] rel_cnt_q, rel_cnt_d;
  logic [4:0] units_q, units_d;
  logic [4:0] sub_q, sub_d;
  logic [7:0] note_q, note_d;
  logic [3:0] duration_q, duration_d;
  logic       note_dec_q, note_dec_d;
  logic       tracking_q, tracking_d;

  logic       silent;
  logic       same;
  logic [3:0] held_dur;
  logic [4:0] units_n;
  logic [4:0] sub_n;

  always_comb begin
    silent = !((frame_note[7:4] == 4'b1000) || (frame_note[7:4] >= 4'b1010));
    same   = (frame_note == cand_q);
    held_dur = (units_q > MAX_U5) ? MAX_U4 : units_q[3:0];
    if (sub_q == FPU) begin
      units_n = units_q + 5'd1;
      sub_n   = 5'd1;
    end else begin
      units_n = units_q;
      sub_n   = sub_q + 5'd1;
    end

    state_d    = state_q;
    cand_d     = cand_q;
    cand_cnt_d = cand_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    units_d    = units_q;
    sub_d      = sub_q;
    note_d     = note_q;
    duration_d = duration_q;
    note_dec_d = 1'b0;

    if (flush) begin
      if (state_q == HOLD) begin
        note_d     = cand_q;
        duration_d = held_dur;
        note_dec_d = 1'b1;
      end
      state_d    = IDLE;
      cand_cnt_d = '0;
      rel_cnt_d  = '0;
      units_d    = '0;
      sub_d      = '0;
    end else if (frame_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!silent) begin
            cand_d     = frame_note;
            cand_cnt_d = 4'd1;
            state_d    = CAND;
          end
        end
        CAND: begin
          if (silent) begin
            cand_cnt_d = '0;
            state_d    = IDLE;
          end else if (same) begin
            if (({1'b0, cand_cnt_q} + 5'd1) == STABLE_N) begin
              cand_cnt_d = '0;
              rel_cnt_d  = '0;
              units_d    = INIT_UNITS;
              sub_d      = INIT_SUB;
              if (INIT_SAT) begin
                note_d     = cand_q;
                duration_d = INIT_DUR;
                note_dec_d = 1'b1;
                state_d    = LOCK;
              end else begin
                state_d = HOLD;
              end
            end else begin
              cand_cnt_d = cand_cnt_q + 4'd1;
            end
          end else begin
            cand_d     = frame_note;
            cand_cnt_d = 4'd1;
          end
        end
        HOLD: begin
          if (silent) begin
            if (({1'b0, rel_cnt_q} + 5'd1) == RELEASE_N) begin
              note_d     = cand_q;
              duration_d = held_dur;
              note_dec_d = 1'b1;
              rel_cnt_d  = '0;
              state_d    = IDLE;
            end else begin
              rel_cnt_d = rel_cnt_q + 4'd1;
            end
          end else if (same) begin
            rel_cnt_d = '0;
            units_d   = units_n;
            sub_d     = sub_n;
            if ((units_n == MAX_U5) && (sub_n == FPU)) begin
              note_d     = cand_q;
              duration_d = MAX_U4;
              note_dec_d = 1'b1;
              state_d    = LOCK;
            end
          end else begin
            note_d     = cand_q;
            duration_d = held_dur;
            note_dec_d = 1'b1;
            cand_d     = frame_note;
            cand_cnt_d = 4'd1;
            rel_cnt_d  = '0;
            state_d    = CAND;
          end
        end
        LOCK: begin
          if (silent) begin
            state_d = IDLE;
          end else if (!same) begin
            cand_d     = frame_note;
            cand_cnt_d = 4'd1;
            state_d    = CAND;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    tracking_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cand_cnt_q <= '0;
      rel_cnt_q  <= '0;
      units_q    <= '0;
      sub_q      <= '0;
      note_q     <= '0;
      duration_q <= '0;
      note_dec_q <= 1'b0;
      tracking_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cand_cnt_q <= cand_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      units_q    <= units_d;
      sub_q      <= sub_d;
      note_q     <= note_d;
      duration_q <= duration_d;
      note_dec_q <= note_dec_d;
      tracking_q <= tracking_d;
    end
  end

  assign note     = note_q;
  assign duration = duration_q;
  assign note_dec = note_dec_q;
  assign tracking = tracking_q;

endmodule
